// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer between pipeline stages, with registered ready/valid.
// Optional stall statistics counter is enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_reg;
    logic [WIDTH-1:0] skid_next;
    logic             accept;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_skid_reg: WIDTH and CNT_W must be at least 1");
    end

    // Handshake flags decode straight from the state register, so nothing
    // combinational crosses the stage boundary.
    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign out_data  = main_reg;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            // Drop validity only; payload registers keep their contents.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        main_next  = in_data;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        main_next = in_data;
                    end else if (accept) begin
                        skid_next  = in_data;
                        state_next = ST_FULL;
                    end else if (out_ready) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        main_next  = skid_reg;
                        state_next = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_count_reg;

    // Saturating count of cycles where held data waits on the downstream stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if (out_valid && !out_ready && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule
